// File: rtl/monitor_stage_sched.sv
// ---------------------------------------------------------------------------
// MonitorStageSched: controller for one cluster stage of LTL automata
// monitors.
//
// Trace symbols arrive over a valid/ready handshake. Each accepted symbol is
// handed to the stage as a one-cycle run pulse. The stage's report vector is
// sampled REPORT_LAT cycles after that pulse. Every set report bit is turned
// into a (report id, symbol index) event. Events are queued in a small FIFO
// and streamed out over valid/ready.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   sym_valid      symbol offered by the trace front-end
//   sym_ready      symbol accepted when sym_valid and sym_ready are both high
//   sym_data       symbol value
//   flush_req      level request to reset the stage automata and symbol index
//   run            one-cycle strobe to the stage
//   stage_reset    active-high reset to the stage
//   stage_symbols  symbol driven to the stage
//   reports_in     report bits from the stage
//   rpt_valid      report FIFO not empty
//   rpt_ready      consumer pops the head entry
//   rpt_id         head entry: index of the report bit
//   rpt_cycle      head entry: index of the symbol that produced the report
//   busy           controller not idle in ACCEPT, or reports still queued
// ---------------------------------------------------------------------------
module monitor_stage_sched #(
   parameter int NUM_REPORTS = 40,
   parameter int ID_W        = 6,
   parameter int SYM_W       = 8,
   parameter int CYC_W       = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int REPORT_LAT  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sym_valid,
   output logic                   sym_ready,
   input  logic [SYM_W-1:0]       sym_data,
   input  logic                   flush_req,
   output logic                   run,
   output logic                   stage_reset,
   output logic [SYM_W-1:0]       stage_symbols,
   input  logic [NUM_REPORTS-1:0] reports_in,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [ID_W-1:0]        rpt_id,
   output logic [CYC_W-1:0]       rpt_cycle,
   output logic                   busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = (REPORT_LAT < 2) ? 1 : $clog2(REPORT_LAT + 1);

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      ACCEPT = 3'd1,
      WAIT   = 3'd2,
      SCAN   = 3'd3,
      FLUSH  = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;

   logic                   r_run;
   logic                   r_stage_reset;
   logic [SYM_W-1:0]       r_stage_symbols;
   logic [CYC_W-1:0]       r_sym_idx;
   logic [CYC_W-1:0]       r_cur_idx;
   logic [NUM_REPORTS-1:0] r_pending;
   logic [LAT_W-1:0]       r_lat_cnt;

   logic [ID_W-1:0]        r_mem_id  [FIFO_DEPTH];
   logic [CYC_W-1:0]       r_mem_cyc [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;

   logic                   w_handshake;
   logic                   w_sample;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_push_ok;
   logic                   w_rpt_valid;
   logic [ID_W-1:0]        w_low_id;
   logic [NUM_REPORTS-1:0] w_pending_cleared;

   // Queue status. The head is only exposed while there is something in the
   // queue, so the id/cycle outputs read zero when the FIFO is empty.
   assign w_rpt_valid = (r_count != '0);
   assign w_pop       = w_rpt_valid & rpt_ready;
   assign w_push_ok   = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;

   assign sym_ready     = (r_state == ACCEPT) & ~flush_req;
   assign run           = r_run;
   assign stage_reset   = r_stage_reset;
   assign stage_symbols = r_stage_symbols;
   assign rpt_valid     = w_rpt_valid;
   assign rpt_id        = w_rpt_valid ? r_mem_id[r_rd_ptr]  : '0;
   assign rpt_cycle     = w_rpt_valid ? r_mem_cyc[r_rd_ptr] : '0;
   assign busy          = (r_state != ACCEPT) | w_rpt_valid;

   // Priority encoder picking the lowest set pending bit, so reports leave
   // the stage in ascending id order. The loop runs high-to-low so the last
   // hit, the lowest index, wins.
   always_comb begin
      w_low_id = '0;
      for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_low_id = ID_W'(i);
         end
      end
      w_pending_cleared = r_pending & ~(NUM_REPORTS'(1) << w_low_id);
   end

   // Next-state logic. flush_req is only looked at in ACCEPT, so a flush
   // raised during WAIT or SCAN waits until the current symbol is fully
   // reported. A blocked push keeps the FSM in SCAN with pending untouched,
   // which is how FIFO back-pressure stalls the symbol input.
   always_comb begin
      w_next_state = r_state;
      w_handshake  = 1'b0;
      w_sample     = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         INIT: begin
            w_next_state = ACCEPT;
         end
         ACCEPT: begin
            if (flush_req) begin
               w_next_state = FLUSH;
            end else if (sym_valid) begin
               w_handshake  = 1'b1;
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (r_lat_cnt == LAT_W'(REPORT_LAT)) begin
               w_sample     = 1'b1;
               w_next_state = (reports_in != '0) ? SCAN : ACCEPT;
            end
         end
         SCAN: begin
            if (w_push_ok) begin
               w_push = 1'b1;
               if (w_pending_cleared == '0) begin
                  w_next_state = ACCEPT;
               end
            end
         end
         FLUSH: begin
            w_next_state = ACCEPT;
         end
         default: begin
            w_next_state = INIT;
         end
      endcase
   end

   // State register and stage-facing outputs. The stage reset is driven
   // from the next state so that it lines up with the INIT and FLUSH cycles.
   // The symbol index advances on every accepted symbol and wraps naturally;
   // the index of the symbol in flight is kept in r_cur_idx for tagging.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= INIT;
         r_run           <= 1'b0;
         r_stage_reset   <= 1'b1;
         r_stage_symbols <= '0;
         r_sym_idx       <= '0;
         r_cur_idx       <= '0;
         r_pending       <= '0;
         r_lat_cnt       <= '0;
      end else begin
         r_state       <= w_next_state;
         r_run         <= w_handshake;
         r_stage_reset <= (w_next_state == FLUSH) || (w_next_state == INIT);
         if (w_handshake) begin
            r_stage_symbols <= sym_data;
            r_cur_idx       <= r_sym_idx;
            r_sym_idx       <= r_sym_idx + 1'b1;
            r_lat_cnt       <= '0;
         end else if (r_state == WAIT) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
         end
         if (r_state == FLUSH) begin
            r_sym_idx <= '0;
         end
         if (w_sample) begin
            r_pending <= reports_in;
         end else if (w_push) begin
            r_pending <= w_pending_cleared;
         end
      end
   end

   // FIFO bookkeeping. Depth is a power of two so the pointers simply wrap.
   // A push and a pop in the same cycle leave the occupancy unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // FIFO storage. It needs no reset: entries are only visible through the
   // occupancy count, which is cleared on reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_id[r_wr_ptr]  <= w_low_id;
         r_mem_cyc[r_wr_ptr] <= r_cur_idx;
      end
   end

endmodule

// File: tb/tb_monitor_stage_sched.sv
// ---------------------------------------------------------------------------
// Directed testbench for monitor_stage_sched, built with CYC_W=4 so the
// symbol index wrap can be reached with a few symbols.
// ---------------------------------------------------------------------------
module tb_monitor_stage_sched;

   localparam int NUM_REPORTS = 40;
   localparam int ID_W        = 6;
   localparam int SYM_W       = 8;
   localparam int CYC_W       = 4;

   logic                   clk;
   logic                   reset;
   logic                   sym_valid;
   logic                   sym_ready;
   logic [SYM_W-1:0]       sym_data;
   logic                   flush_req;
   logic                   run;
   logic                   stage_reset;
   logic [SYM_W-1:0]       stage_symbols;
   logic [NUM_REPORTS-1:0] reports_in;
   logic                   rpt_valid;
   logic                   rpt_ready;
   logic [ID_W-1:0]        rpt_id;
   logic [CYC_W-1:0]       rpt_cycle;
   logic                   busy;

   int passCount  = 0;
   int checkCount = 0;
   int cycleCount = 0;
   int lastRunCycle = 0;

   monitor_stage_sched #(
      .NUM_REPORTS(NUM_REPORTS),
      .ID_W(ID_W),
      .SYM_W(SYM_W),
      .CYC_W(CYC_W),
      .FIFO_DEPTH(8),
      .REPORT_LAT(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sym_valid(sym_valid),
      .sym_ready(sym_ready),
      .sym_data(sym_data),
      .flush_req(flush_req),
      .run(run),
      .stage_reset(stage_reset),
      .stage_symbols(stage_symbols),
      .reports_in(reports_in),
      .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready),
      .rpt_id(rpt_id),
      .rpt_cycle(rpt_cycle),
      .busy(busy)
   );

   // Free-running clock and a cycle counter used to measure run spacing.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // One comparison: counts it, and on a miss reports tag and values.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount = checkCount + 1;
      assert (observed === expected) begin
         passCount = passCount + 1;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offers one symbol, checks the run pulse, presents the report vector
   // during the WAIT window and returns on the cycle after it was sampled.
   task automatic applyStimulus(input logic [SYM_W-1:0] sym,
                                input logic [NUM_REPORTS-1:0] rep);
      int waitCycles;
      waitCycles = 0;
      sym_valid = 1'b1;
      sym_data  = sym;
      while (sym_ready !== 1'b1 && waitCycles < 60) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("accept_in_time", 64'(waitCycles < 60), 64'd1);
      @(negedge clk);
      sym_valid = 1'b0;
      checkOutput("run_pulse", 64'(run), 64'd1);
      checkOutput("stage_symbols", 64'(stage_symbols), 64'(sym));
      lastRunCycle = cycleCount;
      reports_in = rep;
      @(negedge clk);
      checkOutput("run_one_cycle", 64'(run), 64'd0);
      @(negedge clk);
      reports_in = '0;
   endtask

   // Checks the head entry then lets it be popped on the next edge.
   task automatic expectPop(input string tag, input int id, input int cyc);
      checkOutput({tag, "_valid"}, 64'(rpt_valid), 64'd1);
      checkOutput({tag, "_id"}, 64'(rpt_id), 64'(id));
      checkOutput({tag, "_cycle"}, 64'(rpt_cycle), 64'(cyc));
      @(negedge clk);
   endtask

   initial begin
      int firstRun;
      int burstIds[10];
      logic [NUM_REPORTS-1:0] burst;

      burstIds = '{0, 1, 2, 5, 10, 20, 30, 35, 38, 39};
      reset      = 1'b0;
      sym_valid  = 1'b0;
      sym_data   = '0;
      flush_req  = 1'b0;
      reports_in = '0;
      rpt_ready  = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_run", 64'(run), 64'd0);
      checkOutput("rst_stage_reset", 64'(stage_reset), 64'd1);
      checkOutput("rst_stage_symbols", 64'(stage_symbols), 64'd0);
      checkOutput("rst_sym_ready", 64'(sym_ready), 64'd0);
      checkOutput("rst_rpt_valid", 64'(rpt_valid), 64'd0);
      checkOutput("rst_rpt_id", 64'(rpt_id), 64'd0);
      checkOutput("rst_rpt_cycle", 64'(rpt_cycle), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd1);

      // Release: stage_reset stays high through the single INIT cycle.
      reset = 1'b1;
      #1;
      checkOutput("init_stage_reset", 64'(stage_reset), 64'd1);
      @(negedge clk);
      checkOutput("init_done_stage_reset", 64'(stage_reset), 64'd0);
      checkOutput("accept_sym_ready", 64'(sym_ready), 64'd1);
      checkOutput("accept_idle_busy", 64'(busy), 64'd0);

      // Back-to-back symbols with no reports: runs are 3 cycles apart.
      applyStimulus(8'h11, '0);
      firstRun = lastRunCycle;
      applyStimulus(8'h22, '0);
      checkOutput("run_spacing", 64'(lastRunCycle - firstRun), 64'd3);
      checkOutput("no_reports", 64'(rpt_valid), 64'd0);
      applyStimulus(8'h33, '0);
      applyStimulus(8'h44, '0);

      // Symbol index 4 reports bits 3, 9 and 39 with the consumer ready.
      rpt_ready = 1'b1;
      applyStimulus(8'h55, (40'd1 << 3) | (40'd1 << 9) | (40'd1 << 39));
      checkOutput("scan_sym_ready", 64'(sym_ready), 64'd0);
      checkOutput("scan_busy", 64'(busy), 64'd1);
      checkOutput("scan_first_empty", 64'(rpt_valid), 64'd0);
      @(negedge clk);
      expectPop("r3", 3, 4);
      checkOutput("scan_mid_sym_ready", 64'(sym_ready), 64'd0);
      expectPop("r9", 9, 4);
      checkOutput("scan_end_sym_ready", 64'(sym_ready), 64'd1);
      expectPop("r39", 39, 4);
      checkOutput("drained_valid", 64'(rpt_valid), 64'd0);

      // Ten reports with the consumer stalled: eight queue up, scan stalls.
      rpt_ready = 1'b0;
      burst = '0;
      for (int k = 0; k < 10; k++) burst[burstIds[k]] = 1'b1;
      applyStimulus(8'h66, burst);
      repeat (12) @(negedge clk);
      checkOutput("full_valid", 64'(rpt_valid), 64'd1);
      checkOutput("full_sym_ready", 64'(sym_ready), 64'd0);
      checkOutput("full_busy", 64'(busy), 64'd1);
      rpt_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         expectPop("burst", burstIds[k], 5);
      end
      checkOutput("burst_drained", 64'(rpt_valid), 64'd0);
      checkOutput("burst_sym_ready", 64'(sym_ready), 64'd1);

      // Flush raised during SCAN is deferred, then pulses stage_reset once.
      rpt_ready = 1'b0;
      applyStimulus(8'h77, (40'd1 << 4) | (40'd1 << 7));
      flush_req = 1'b1;
      @(negedge clk);
      checkOutput("flush_defer_reset", 64'(stage_reset), 64'd0);
      @(negedge clk);
      checkOutput("flush_accept_ready", 64'(sym_ready), 64'd0);
      checkOutput("flush_accept_reset", 64'(stage_reset), 64'd0);
      @(negedge clk);
      checkOutput("flush_pulse", 64'(stage_reset), 64'd1);
      flush_req = 1'b0;
      @(negedge clk);
      checkOutput("flush_pulse_end", 64'(stage_reset), 64'd0);
      checkOutput("flush_sym_ready", 64'(sym_ready), 64'd1);
      checkOutput("flush_kept_fifo", 64'(rpt_valid), 64'd1);
      applyStimulus(8'h88, 40'd1 << 2);
      @(negedge clk);
      rpt_ready = 1'b1;
      expectPop("pre_flush_a", 4, 6);
      expectPop("pre_flush_b", 7, 6);
      expectPop("post_flush", 2, 0);
      checkOutput("flush_drained", 64'(rpt_valid), 64'd0);

      // Symbol index wrap: indices 1..14 silent, 15 reports, then 0.
      for (int k = 1; k < 15; k++) applyStimulus(8'(k), '0);
      applyStimulus(8'hF0, 40'd1);
      @(negedge clk);
      expectPop("idx15", 0, 15);
      applyStimulus(8'hF1, 40'd1 << 1);
      @(negedge clk);
      expectPop("idx_wrap", 1, 0);

      // Reset while three entries are queued and reports are pending.
      rpt_ready = 1'b0;
      applyStimulus(8'h99, 40'h3F);
      repeat (3) @(negedge clk);
      checkOutput("pre_reset_valid", 64'(rpt_valid), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid_reset_valid", 64'(rpt_valid), 64'd0);
      checkOutput("mid_reset_stage_reset", 64'(stage_reset), 64'd1);
      checkOutput("mid_reset_busy", 64'(busy), 64'd1);
      checkOutput("mid_reset_sym_ready", 64'(sym_ready), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rerelease_stage_reset", 64'(stage_reset), 64'd1);
      @(negedge clk);
      checkOutput("rerelease_done", 64'(stage_reset), 64'd0);
      checkOutput("rerelease_empty", 64'(rpt_valid), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("no_stale_entries", 64'(rpt_valid), 64'd0);
      applyStimulus(8'hAA, 40'd1 << 8);
      @(negedge clk);
      expectPop("after_reset_head", 8, 0);
      checkOutput("after_reset_single", 64'(rpt_valid), 64'd1);
      rpt_ready = 1'b1;
      @(negedge clk);
      checkOutput("after_reset_drained", 64'(rpt_valid), 64'd0);
      checkOutput("after_reset_idle", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/monitor_stage_sched.md
Name: monitor_stage_sched

Overview:
- Controller that sequences one cluster stage of LTL automata monitors: 8-bit symbols, a run strobe and a stage reset go in; a vector of report bits comes out.
- Accepts trace symbols over a valid/ready handshake and issues each symbol to the stage as a one-cycle run pulse.
- Samples the stage's report vector, serialises set bits into (report id, symbol index) events, buffers them in a FIFO and streams them out over valid/ready.
- Sits between the trace front-end and the cluster stage.

Parameters:
- NUM_REPORTS, 40, width of the report vector from the stage
- ID_W, 6, report id width, ceil(log2(NUM_REPORTS))
- SYM_W, 8, symbol width
- CYC_W, 32, symbol index width
- FIFO_DEPTH, 8, report FIFO entries (power of 2, at least 2)
- REPORT_LAT, 1, cycles after the run cycle at which reports_in is sampled (at least 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- sym_valid  in  1  symbol offered
- sym_ready  out  1  symbol accepted when both valid and ready are high
- sym_data  in  SYM_W  symbol
- flush_req  in  1  level request: reset the stage automata and the symbol index
- run  out  1  one-cycle strobe to the stage
- stage_reset  out  1  active-high reset to the stage
- stage_symbols  out  SYM_W  symbol driven to the stage
- reports_in  in  NUM_REPORTS  stage report bits
- rpt_valid  out  1  FIFO not empty
- rpt_ready  in  1  consumer pops the head entry
- rpt_id  out  ID_W  head entry: index of the report bit
- rpt_cycle  out  CYC_W  head entry: index of the symbol that produced the report
- busy  out  1  high when state is not ACCEPT or the FIFO is not empty

Behaviour:
- Reset values (asynchronous assert, reset low): run=0, stage_reset=1, stage_symbols=0, sym_ready=0, rpt_valid=0, rpt_id=0, rpt_cycle=0, busy=1, FIFO empty, sym_idx=0, pending=0, state=INIT.
- All outputs are registered except these, which are decodes of registered state: sym_ready, rpt_valid, rpt_id, rpt_cycle, busy.
- FSM states: INIT, ACCEPT, WAIT, SCAN, FLUSH.
- INIT:
  - stage_reset=1 for exactly one cycle after reset deasserts.
  - Next state: ACCEPT.
- ACCEPT:
  - sym_ready = 1 only when state is ACCEPT and flush_req is low.
  - flush_req has priority over a pending symbol: if flush_req is high, go to FLUSH.
  - On a handshake at cycle t: at t+1 run=1 and stage_symbols=sym_data; the accepted symbol's index is held in cur_idx; sym_idx increments, wrapping modulo 2^CYC_W; next state is WAIT.
- WAIT:
  - run returns to 0; stage_symbols holds its value.
  - Counts REPORT_LAT cycles, then samples reports_in into pending.
  - If pending is nonzero, go to SCAN; otherwise go to ACCEPT.
  - Peak throughput is one symbol per REPORT_LAT+2 cycles.
- SCAN:
  - Each cycle, the lowest set bit of pending is pushed as {id, cur_idx} and that bit is cleared.
  - A push is allowed when the FIFO count is below FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
  - If a push is blocked, the FSM stays in SCAN with pending unchanged. No report is ever dropped; back-pressure reaches sym_ready.
  - After the last bit is pushed, go to ACCEPT.
- FLUSH:
  - stage_reset=1 for one cycle; sym_idx is cleared to 0.
  - FIFO contents are kept.
  - Next state: ACCEPT.
  - A flush_req that is still high on return to ACCEPT triggers another flush.
- flush_req is ignored in WAIT and SCAN; it takes effect at the next ACCEPT.
- FIFO:
  - The head is shown on rpt_id / rpt_cycle while rpt_valid is high.
  - A pop occurs when rpt_valid and rpt_ready are both high.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation: everything returns to the reset values immediately; pending reports and FIFO contents are discarded.

Test Plan:
- Reset release, then symbols 0x11, 0x22 offered back-to-back with reports_in=0: stage_reset high for 1 cycle; run pulses with stage_symbols 0x11 then 0x22, spaced 3 cycles apart (REPORT_LAT=1); rpt_valid stays 0.
- 5th symbol (index 4) yields reports_in bits 3, 9, 39, rpt_ready=1: FIFO outputs (3,4), (9,4), (39,4) in order on consecutive cycles; sym_ready stays low until the scan completes.
- rpt_ready=0, 10 set report bits, FIFO_DEPTH=8: 8 entries are queued and the FSM stalls in SCAN with sym_ready=0. Then raise rpt_ready: all 10 entries come out in id order with none lost, and sym_ready returns.
- flush_req raised while in SCAN: the flush is deferred until the scan ends; then stage_reset pulses once; the next symbol reports rpt_cycle=0; earlier FIFO entries are retained.
- sym_idx preset near 2^CYC_W-1 (force or CYC_W=4): rpt_cycle reads 15, then wraps to 0 on the following symbol.
- reset asserted while FIFO holds 3 entries and pending is nonzero: rpt_valid=0 immediately; after release, the INIT stage_reset pulse occurs and no stale entries appear.
